// File: rtl/mlp_share_arbiter_if.sv
// mlp_share_arbiter_if: requester, engine and response signals shared by the arbiter and its environment
interface mlp_share_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int EMBED_DIM  = 128
);
  localparam int VW = DATA_WIDTH * EMBED_DIM;
  localparam int IW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*VW-1:0] req_vec;
  logic                  mlp_start;
  logic                  mlp_in_valid;
  logic [VW-1:0]         mlp_in_vec;
  logic                  mlp_out_valid;
  logic [VW-1:0]         mlp_out_vec;
  logic                  mlp_done;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IW-1:0]         rsp_id;
  logic [VW-1:0]         rsp_vec;
  modport master (
    input  req_valid, req_vec, mlp_out_valid, mlp_out_vec, mlp_done, rsp_ready,
    output req_ready, mlp_start, mlp_in_valid, mlp_in_vec, rsp_valid, rsp_id, rsp_vec
  );
  modport slave (
    output req_valid, req_vec, mlp_out_valid, mlp_out_vec, mlp_done, rsp_ready,
    input  req_ready, mlp_start, mlp_in_valid, mlp_in_vec, rsp_valid, rsp_id, rsp_vec
  );
endinterface

// File: rtl/mlp_share_arbiter.sv
// mlp_share_arbiter: round-robin sharing of one mlp_block engine among NUM_REQ requesters.
// Define MLP_ARB_TIMEOUT_EN to enable the WAIT-state watchdog.
module mlp_share_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int EMBED_DIM      = 128,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  mlp_share_arbiter_if.master bus,
  output logic                busy,
  output logic                timeout_err
);
  localparam int VW = DATA_WIDTH * EMBED_DIM;
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t        r_state, w_next;
  logic [IW-1:0] r_rr_ptr, r_cur_id, w_grant;
  logic [VW-1:0] r_in_vec, r_rsp_vec;
  logic          w_found, w_to, w_fire, w_take;
  logic          r_got_res, r_start, r_rsp_valid;

  // Descending scan so the nearest valid requester after rr_ptr wins.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (bus.req_valid[IW'((int'(r_rr_ptr) + k) % NUM_REQ)]) begin
        w_grant = IW'((int'(r_rr_ptr) + k) % NUM_REQ);
        w_found = 1'b1;
      end
  end

  assign w_take = r_state == IDLE && w_found;
  assign w_fire = r_rsp_valid && bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;

  always_comb begin
    w_next = r_state;
    if (w_take) w_next = ISSUE;
    else if (r_state == ISSUE) w_next = WAIT;
    else if (r_state == WAIT && (w_to || (bus.mlp_done && (r_got_res || bus.mlp_out_valid)))) w_next = RESP;
    else if (r_state == RESP && w_fire) w_next = IDLE;
  end

  always_comb begin
    bus.req_ready = w_take ? NUM_REQ'(1) << w_grant : '0;
    busy          = r_state != IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rr_ptr    <= IW'(NUM_REQ - 1);
      r_cur_id    <= '0;
      r_in_vec    <= '0;
      r_rsp_vec   <= '0;
      r_got_res   <= 1'b0;
      r_start     <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_start <= w_take;
      if (w_take) begin
        r_rr_ptr <= w_grant;
        r_cur_id <= w_grant;
        r_in_vec <= bus.req_vec[int'(w_grant)*VW +: VW];
      end
      if (r_state == WAIT && bus.mlp_out_valid) begin
        r_rsp_vec <= bus.mlp_out_vec;
        r_got_res <= 1'b1;
      end
      if (w_to) r_rsp_vec <= '0;
      if (r_state == WAIT && w_next == RESP) r_rsp_valid <= 1'b1;
      if (w_fire) begin
        r_rsp_valid <= 1'b0;
        r_got_res   <= 1'b0;
      end
    end

`ifdef MLP_ARB_TIMEOUT_EN
  logic [15:0] r_wd;
  logic        r_to_err;
  assign w_to        = r_state == WAIT && r_wd == 16'(TIMEOUT_CYCLES - 1);
  assign timeout_err = r_to_err;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wd     <= '0;
      r_to_err <= 1'b0;
    end else begin
      r_wd <= (r_state == WAIT) ? r_wd + 16'd1 : '0;
      if (w_to) r_to_err <= 1'b1;
    end
`else
  logic w_unused_to;
  assign w_to        = 1'b0;
  assign timeout_err = 1'b0;
  assign w_unused_to = TIMEOUT_CYCLES == 0;
`endif

  assign bus.mlp_start    = r_start;
  assign bus.mlp_in_valid = r_start;
  assign bus.mlp_in_vec   = r_in_vec;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_id       = r_cur_id;
  assign bus.rsp_vec      = r_rsp_vec;
endmodule

// File: tb/tb_mlp_share_arbiter.sv
// tb_mlp_share_arbiter: scoreboard bench for mlp_share_arbiter with a stub engine and requester agent.
module tb_mlp_share_arbiter;
  localparam int NUM = 4, DW = 8, ED = 4, VW = DW * ED, TO = 16;
  typedef struct packed {logic [1:0] id; logic [VW-1:0] vec;} exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic busy, timeout_err;
  int   total = 0, bad = 0, cyc = 0;
  int   mode = 0, exp_lat = -1, starts = 0, rsps = 0, start_cyc = 0, ngrant = 0;
  logic [NUM-1:0] last_g = '0;
  exp_t sb[$];
  logic [VW-1:0] pq[NUM][$];

  mlp_share_arbiter_if #(.NUM_REQ(NUM), .DATA_WIDTH(DW), .EMBED_DIM(ED)) bus ();
  mlp_share_arbiter #(.NUM_REQ(NUM), .DATA_WIDTH(DW), .EMBED_DIM(ED), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .timeout_err(timeout_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [VW-1:0] eng(input logic [VW-1:0] v);
    return (v ^ 32'h5A5A_0F0F) + 32'd3;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic submit(input int id, input logic [VW-1:0] v, input logic [VW-1:0] e);
    pq[id].push_back(v);
    sb.push_back({2'(id), e});
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((sb.size() != 0 || busy || bus.req_valid != '0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL %s: timed out with %0d responses outstanding", nm, sb.size());
    end
  endtask

  // Requester agent: holds each vector until its req_ready is seen.
  initial begin
    logic [NUM-1:0] g;
    bus.req_valid = '0;
    bus.req_vec   = '0;
    forever begin
      @(negedge clk);
      g = rst_n ? bus.req_ready : '0;
      if (g != '0) begin
        check("req_ready_onehot", 64'($onehot(g) && (g & ~bus.req_valid) == '0), 64'd1);
        last_g = g;
        ngrant++;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM; i++)
        if (g[i] || !bus.req_valid[i]) begin
          if (pq[i].size() != 0) begin
            bus.req_vec[i*VW +: VW] = pq[i].pop_front();
            bus.req_valid[i] = 1'b1;
          end else bus.req_valid[i] = 1'b0;
        end
    end
  end

  // Stub engine: 0 standard, 1 same-cycle result+done, 2 silent, 3 early stray done.
  initial begin
    logic [VW-1:0] v;
    bus.mlp_out_valid = 1'b0;
    bus.mlp_done      = 1'b0;
    bus.mlp_out_vec   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mlp_start && mode != 2) begin
        check("in_valid_with_start", 64'(bus.mlp_in_valid), 64'd1);
        v = eng(bus.mlp_in_vec);
        @(posedge clk);
        #1;
        if (mode == 3) begin
          bus.mlp_done = 1'b1;
          @(posedge clk);
          #1;
          bus.mlp_done = 1'b0;
        end
        bus.mlp_out_valid = 1'b1;
        bus.mlp_out_vec   = v;
        bus.mlp_done      = mode == 1;
        @(posedge clk);
        #1;
        bus.mlp_out_valid = 1'b0;
        if (mode != 1) begin
          bus.mlp_done = 1'b1;
          @(posedge clk);
          #1;
        end
        bus.mlp_done = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on each accepted response and checks holds and latency.
  initial begin
    logic pv = 1'b0, pr = 1'b0, ps = 1'b0;
    logic [1:0] pid = '0;
    logic [VW-1:0] pvec = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.mlp_start) begin
        check("start_single_pulse", 64'(ps), 64'd0);
        starts++;
        start_cyc = cyc;
      end
      if (pv && !pr && rst_n)
        check("rsp_hold", 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_vec}), 64'({1'b1, pid, pvec}));
      if (bus.rsp_valid && !pv && exp_lat >= 0)
        check("rsp_latency", 64'(cyc - start_cyc), 64'(exp_lat));
      if (bus.rsp_valid && bus.rsp_ready) begin
        rsps++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: got id %0d with none expected", bus.rsp_id);
        end else begin
          e = sb.pop_front();
          check("rsp_id", 64'(bus.rsp_id), 64'(e.id));
          check("rsp_vec", 64'(bus.rsp_vec), 64'(e.vec));
        end
      end
      pv = bus.rsp_valid; pr = bus.rsp_ready; ps = bus.mlp_start;
      pid = bus.rsp_id; pvec = bus.rsp_vec;
    end
  end

  initial begin
    int n, s0, g0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_outputs", 64'({bus.mlp_start, bus.mlp_in_valid, bus.rsp_valid, timeout_err}), 64'd0);
    rst_n = 1'b1;

    // All four continuously valid: rotation 0,1,2,3,0
    exp_lat = 3;
    for (int i = 0; i < NUM; i++) submit(i, 32'h1000_0000 * (i + 1) + 32'h55, eng(32'h1000_0000 * (i + 1) + 32'h55));
    submit(0, 32'hCAFE_F00D, eng(32'hCAFE_F00D));
    drain("rotation");

    // Single request from requester 2
    g0 = ngrant; s0 = starts;
    submit(2, 32'hA5A5_1234, eng(32'hA5A5_1234));
    drain("single");
    check("single_req_ready", 64'(last_g), 64'b0100);
    check("single_one_start", 64'(starts - s0), 64'd1);
    check("single_one_grant", 64'(ngrant - g0), 64'd1);

    // Backpressure: 20 cycles held in RESP while another requester waits
    bus.rsp_ready = 1'b0;
    submit(1, 32'h0BAD_BEEF, eng(32'h0BAD_BEEF));
    n = 0;
    while (!bus.rsp_valid && n < 100) begin @(posedge clk); n++; end
    #1;
    check("bp_rsp_seen", 64'(n < 100), 64'd1);
    submit(3, 32'h7777_0001, eng(32'h7777_0001));
    g0 = ngrant; s0 = starts;
    repeat (20) @(posedge clk);
    #1;
    check("bp_no_grant", 64'(ngrant - g0), 64'd0);
    check("bp_no_start", 64'(starts - s0), 64'd0);
    bus.rsp_ready = 1'b1;
    drain("backpressure");

    // Same-cycle result and done, then a stray done before the result
    mode = 1; exp_lat = 2;
    submit(0, 32'h1357_9BDF, eng(32'h1357_9BDF));
    drain("same_cycle");
    mode = 3; exp_lat = 4;
    submit(3, 32'hFEDC_BA98, eng(32'hFEDC_BA98));
    drain("early_done");

`ifdef MLP_ARB_TIMEOUT_EN
    mode = 2; exp_lat = TO + 1;
    submit(1, 32'h2222_3333, 32'h0);
    drain("timeout");
    check("timeout_err_set", 64'(timeout_err), 64'd1);
    mode = 0; exp_lat = 3;
    submit(2, 32'h4444_5555, eng(32'h4444_5555));
    drain("after_timeout");
    check("timeout_err_sticky", 64'(timeout_err), 64'd1);
`else
    check("timeout_err_tied", 64'(timeout_err), 64'd0);
`endif

    // Reset during WAIT; pointer left at 1 so 3 would win without the reset
    mode = 0; exp_lat = 3;
    submit(1, 32'h0101_0101, eng(32'h0101_0101));
    drain("pre_reset");
    mode = 2;
    s0 = starts;
    submit(2, 32'h9999_AAAA, eng(32'h9999_AAAA));
    n = 0;
    while (starts == s0 && n < 50) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_outputs", 64'({bus.mlp_start, bus.rsp_valid, timeout_err}), 64'd0);
    check("rst_mid_vecs", 64'({bus.rsp_vec, bus.mlp_in_vec}), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mode = 0;
    submit(0, 32'h0F0F_0F0F, eng(32'h0F0F_0F0F));
    submit(3, 32'hF0F0_F0F0, eng(32'hF0F0_F0F0));
    drain("post_reset");
    check("starts_vs_rsps", 64'(starts), 64'(rsps + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end
endmodule
